// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read or write request at a time and answers
// with a single-cycle valid_out pulse a fixed LATENCY cycles after acceptance.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic        valid_out,
  output logic [31:0] data_out,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              is_wr_q;
  logic [AW-1:0]     idx_q;
  logic [31:0]       wdata_q;
  logic [31:0]       dout_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept;
  logic              enter_resp;
  logic              req_wr;
  logic [AW-1:0]     req_idx;
  logic [31:0]       req_data;
  logic              unused_addr_bits;

  // Handshake: the requester holds rd_en/wr_en (with addr/data_in) until it sees
  // valid_out; the request is taken at the first rising edge seen in IDLE, and
  // everything on the inputs is ignored from then until the FSM is back in IDLE.
  assign accept = (state_q == S_IDLE) && (rd_en || wr_en);

  // In IDLE the live inputs describe the request (needed when LATENCY is 1),
  // otherwise the copy latched at acceptance does.
  assign req_wr   = (state_q == S_IDLE) ? wr_en            : is_wr_q;
  assign req_idx  = (state_q == S_IDLE) ? addr[AW+1:2]     : idx_q;
  assign req_data = (state_q == S_IDLE) ? data_in          : wdata_q;

  assign enter_resp = ((state_q == S_WAIT) && (cnt_q == 4'd1)) ||
                      (accept && (LATENCY == 1));

  assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_out   = (state_q == S_RESP);
    busy        = (state_q != S_IDLE);
    dbg_state_o = state_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = 4'(LATENCY - 1);
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      dout_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        is_wr_q <= wr_en;
        idx_q   <= addr[AW+1:2];
        wdata_q <= data_in;
      end
      // A simultaneous rd_en/wr_en request is a write, so data_out is left alone.
      if (enter_resp && !req_wr) begin
        dout_q <= mem_q[req_idx];
      end
    end
  end

  // Storage has no reset; rst gating keeps an aborted or in-reset write out.
  always_ff @(posedge clk) begin
    if (enter_resp && req_wr && !rst) begin
      mem_q[req_idx] <= req_data;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-built multi-cycle cases,
// and randomized traffic compared against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  // Reference model: plain word array plus "has been written" flags.
  logic [31:0] mem_m   [DEPTH];
  bit          known_m [DEPTH];
  logic [31:0] dout_m;
  bit          dout_known;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .addr       (addr),
    .data_in    (data_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic model_apply(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int i;
    i = widx(a);
    if (wr) begin
      mem_m[i]   = d;
      known_m[i] = 1'b1;
    end else if (rd) begin
      dout_known = known_m[i];
      dout_m     = mem_m[i];
    end
  endtask

  // Drive one request at a negedge (DUT idle) and follow it to completion.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit chk_d, input logic [31:0] exp_d, input string tag);
    int vk;
    int busy_n;
    vk = 0;
    busy_n = 0;
    rd_en = rd; wr_en = wr; addr = a; data_in = d;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (valid_out) begin
        vk = k;
        rd_en = 1'b0;
        wr_en = 1'b0;
        if (chk_d) check({tag, " data"}, data_out, exp_d);
        break;
      end
      // Inputs are don't-care while the request is in flight.
      addr    = $urandom;
      data_in = $urandom;
    end
    if (vk == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got no valid_out expected pulse within 20 cycles", tag);
      rd_en = 1'b0;
      wr_en = 1'b0;
    end else begin
      check({tag, " latency"}, 32'(vk), 32'(LAT));
      check({tag, " busy cycles"}, 32'(busy_n), 32'(LAT));
      @(negedge clk);
      check({tag, " single pulse"}, {31'd0, valid_out}, 32'd0);
      check({tag, " busy clear"}, {31'd0, busy}, 32'd0);
      if (chk_d) check({tag, " data held"}, data_out, exp_d);
    end
  endtask

  initial begin
    int pulses;
    logic [31:0] mask;
    logic [31:0] exp_mask;
    logic [31:0] ra;
    logic [31:0] rdat;
    bit rr;
    bit rw;
    int sel;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
    dout_m     = 32'd0;
    dout_known = 1'b1;

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = 32'd0; data_in = 32'd0;
    repeat (2) @(negedge clk);
    check("reset valid_out", {31'd0, valid_out}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset data_out", data_out, 32'd0);
    check("reset state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    vecs[0] = '{rd: 1'b0, wr: 1'b1, a: 32'h10,   d: 32'hDEADBEEF, exp_dout: 32'h0};
    vecs[1] = '{rd: 1'b1, wr: 1'b0, a: 32'h10,   d: 32'h0,        exp_dout: 32'hDEADBEEF};
    vecs[2] = '{rd: 1'b1, wr: 1'b1, a: 32'h20,   d: 32'h12345678, exp_dout: 32'hDEADBEEF};
    vecs[3] = '{rd: 1'b1, wr: 1'b0, a: 32'h20,   d: 32'h0,        exp_dout: 32'h12345678};
    vecs[4] = '{rd: 1'b0, wr: 1'b1, a: 32'h1004, d: 32'hA5A5A5A5, exp_dout: 32'h12345678};
    vecs[5] = '{rd: 1'b1, wr: 1'b0, a: 32'h0006, d: 32'h0,        exp_dout: 32'hA5A5A5A5};

    for (int v = 0; v < 6; v++) begin
      model_apply(vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d);
      do_req(vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d, 1'b1, vecs[v].exp_dout,
             $sformatf("vec%0d", v));
    end

    // rd_en held high back-to-back: exactly three responses, LAT+1 cycles apart.
    rd_en = 1'b1; wr_en = 1'b0; addr = 32'h10;
    pulses = 0;
    mask = 32'd0;
    exp_mask = 32'd0;
    for (int p = 0; p < 3; p++) exp_mask[LAT + p * (LAT + 1)] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (valid_out) begin
        pulses++;
        mask[k] = 1'b1;
        check("held rd data", data_out, 32'hDEADBEEF);
        if (pulses == 3) rd_en = 1'b0;
      end
    end
    model_apply(1'b1, 1'b0, 32'h10, 32'h0);
    check("held rd pulse count", 32'(pulses), 32'd3);
    check("held rd pulse timing", mask, exp_mask);

    // Pre-write zero, then abort a write to the same word with reset in WAIT.
    model_apply(1'b0, 1'b1, 32'h30, 32'h0);
    do_req(1'b0, 1'b1, 32'h30, 32'h0, 1'b1, dout_m, "prewrite 0x30");
    wr_en = 1'b1; addr = 32'h30; data_in = 32'hCAFEF00D;
    @(negedge clk);
    check("abort in flight busy", {31'd0, busy}, 32'd1);
    check("abort in flight valid", {31'd0, valid_out}, 32'd0);
    rst = 1'b1;
    #1;
    check("abort rst valid", {31'd0, valid_out}, 32'd0);
    check("abort rst busy", {31'd0, busy}, 32'd0);
    check("abort rst data_out", data_out, 32'd0);
    check("abort rst state", {30'd0, dbg_state}, 32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    check("abort no pulse", {31'd0, valid_out}, 32'd0);
    rst = 1'b0;
    dout_m = 32'd0;
    dout_known = 1'b1;
    model_apply(1'b1, 1'b0, 32'h30, 32'h0);
    do_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, dout_m, "read after abort");

    // Randomized traffic over a few words with aliasing high bits and byte offsets.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      rr = (sel != 0);
      rw = (sel != 1);
      ra = ($urandom_range(0, 7) << 12) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      rdat = $urandom;
      model_apply(rr, rw, ra, rdat);
      exp_q.push_back(dout_m);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(rr, rw, ra, rdat, dout_known, exp_q.pop_front(), $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two, >=2.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port rd_en  input  1  read request from back-end, held until valid_out.
REQ-006 SHALL have port wr_en  input  1  write request from back-end, held until valid_out.
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-008 SHALL have port data_in  input  32  write data (back-end dmem_data_out).
REQ-009 SHALL have port valid_out  output  1  one-cycle response pulse (back-end dmem_valid_in).
REQ-010 SHALL have port data_out  output  32  read data (back-end dmem_data_in).
REQ-011 SHALL have port busy  output  1  high while a request is in flight (states WAIT, RESP).

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-013 SHALL accept a request only in IDLE, at a rising edge with rd_en or wr_en high; addr, data_in and request type latched at acceptance.
REQ-014 SHALL, on acceptance, go to RESP if LATENCY=1, else WAIT with latency counter loaded to LATENCY-1.
REQ-015 SHALL decrement the counter each cycle in WAIT; go to RESP when counter reaches 1 at an edge.
REQ-016 SHALL, for request accepted at edge N, assert valid_out for exactly the cycle following edge N+LATENCY-1 (i.e. LATENCY cycles after acceptance).
REQ-017 SHALL transition RESP -> IDLE unconditionally; no request accepted at the edge ending RESP (min spacing LATENCY+1 cycles).
REQ-018 SHALL ignore rd_en/wr_en changes and addr/data_in changes in WAIT and RESP.
REQ-019 SHALL perform a write into the array at the edge entering RESP; valid_out acknowledges it; data_out unchanged by writes.
REQ-020 SHALL, for a read, drive data_out with array[word index] during RESP and hold that value until the next read response.
REQ-021 SHALL, with rd_en and wr_en both high at acceptance, perform the write only; response is write-ack, data_out unchanged.
REQ-022 SHALL ignore addr[1:0] and address bits above the word index (wrap-around modulo DEPTH_WORDS).
REQ-023 SHALL return previously written data for a read to the same word issued after the write's valid_out.
REQ-024 SHALL keep valid_out and busy purely state-decoded (registered state, no input-to-output combinational path).

Reset
REQ-025 SHALL, on rst high, asynchronously force state IDLE, counter 0, valid_out 0, busy 0, data_out 0.
REQ-026 SHALL abort an in-flight request on reset mid-operation: no valid_out, pending write not performed.
REQ-027 SHALL leave array contents unaffected by reset; contents are undefined before first write.
REQ-028 SHALL accept a request at the first rising edge after rst deasserts, if rd_en/wr_en high.

Verification
REQ-029 SHALL verify: LATENCY=2, write addr 0x10 data 0xDEADBEEF held at edge N -> valid_out high cycle after edge N+1, busy high 2 cycles, data_out stays 0.
REQ-030 SHALL verify: then read addr 0x10 -> valid_out pulse 2 cycles after acceptance, data_out=0xDEADBEEF, held after rd_en drops.
REQ-031 SHALL verify: rd_en held continuously 3 requests, addr 0x10 -> valid_out pulses every 3 cycles, exactly 3 pulses.
REQ-032 SHALL verify: rd_en and wr_en both high, addr 0x20 data 0x12345678 -> one write-ack, data_out unchanged, later read 0x20 returns 0x12345678.
REQ-033 SHALL verify: write addr 0x1004 (DEPTH_WORDS=1024) data 0xA5A5A5A5, read addr 0x0006 -> 0xA5A5A5A5 (wrap and byte-offset ignore).
REQ-034 SHALL verify: write to 0x30 with rst pulsed in WAIT -> no valid_out, outputs 0, subsequent read 0x30 does not return the aborted write data (pre-written 0x0 remains).
